gate_scheduler: RTL and testbench
=================================

Name: gate_scheduler

Overview:
- Sequences the netlist ROM reader and the downstream garbling engine.
- On start, triggers the header read and latches gate_size and num_XOR when the reader reports header done.
- Then issues every gate id 0..gate_size-1 for run_cycles sequential clock cycles through a valid/ready handshake.
- Tags each non-free gate (non-XOR/XNOR) with a running garbled-table index and reports completion and statistics.

Parameters:
- S, 20, width of gate ids, sizes and wire indices; matches the netlist reader.
- C, 16, width of the sequential clock-cycle count.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- run_cycles  in  C  number of sequential cycles to garble; 0 is treated as 1
- nl_start  out  1  one-cycle pulse to the netlist reader's start
- nl_done  in  1  header-done pulse from the netlist reader
- nl_gate_size  in  S  gate count, valid while nl_done=1
- nl_num_xor  in  S  XOR count, valid while nl_done=1
- nl_g_logic  in  4  truth table of the gate currently addressed by gid
- gid  out  S  gate id presented to the netlist reader
- g_valid  out  1  gate descriptor on gid is valid for the engine
- g_ready  in  1  engine accepts the gate
- g_free  out  1  gate is free (g_logic 4'h6 or 4'h9)
- g_tidx  out  S  garbled-table index for non-free gates; don't-care when g_free=1
- g_first  out  1  first gate of a sequential cycle
- g_cyc  out  C  current sequential cycle number
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- tables_total  out  S  gate_size - num_XOR, latched at header

Behaviour:
- Reset values: all outputs 0, state IDLE, header_valid 0.
- Reset mid-run: returns to IDLE immediately; counters and header_valid clear.
- Reset also clears the netlist reader, so the next start re-reads the header.
- Accept: a handshake completes on g_valid & g_ready.
- IDLE:
  - start=1 and header_valid=0 -> HDR.
  - start=1 and header_valid=1 -> ISSUE, reusing the latched header and skipping the header read.
  - busy goes high the cycle after start is sampled.
- HDR:
  - nl_start=1 on the first HDR cycle only.
  - Waits for nl_done; on nl_done, latches gate_size, num_XOR and tables_total, sets header_valid, then goes to ISSUE.
  - The netlist reader enters GARBLE on the same edge, so gid=0 is valid on the first ISSUE cycle.
- ISSUE:
  - g_valid=1, gid=gate counter, g_free decoded combinationally from nl_g_logic.
  - g_tidx = running non-free count; g_first=(gid==0).
  - On accept:
    - If !g_free, the table counter increments.
    - If gid==gate_size-1, go to CYC_END.
    - Otherwise gid increments.
  - Without ready: gid, g_tidx, g_cyc and g_free hold stable; g_valid stays high (no retraction).
- CYC_END (one cycle, g_valid=0):
  - If g_cyc+1 < max(run_cycles,1): g_cyc increments, gid resets to 0, table counter resets to 0, back to ISSUE.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, busy falls, then IDLE. gid returns to 0.
- gate_size=0: HDR goes straight to DONE with no gate issued.
- run_cycles is sampled at start acceptance; later changes are ignored until the next run.
- start while busy is ignored. nl_done outside HDR is ignored.
- Throughput: one gate per cycle under continuous ready. A single-gate cycle costs 2 cycles (ISSUE + CYC_END).
- Widths: counters are S bits unsigned; g_cyc is C bits and never wraps because it is bounded by run_cycles.

Decomposition:
- Shared package holds:
  - state enum (IDLE, HDR, ISSUE, CYC_END, DONE);
  - free-gate truth-table constants XOR_TT=4'h6 and XNOR_TT=4'h9;
  - an is_free(g_logic) function shared with the garbling engine.
- One natural sub-module: gate_issue_counter, holding gid, the table counter and g_cyc with clear/increment controls.
- The FSM stays in the top module.

Test Plan:
- Header capture: rst, start, nl_done pulse with gate_size=5, num_xor=3 -> nl_start pulses exactly once, tables_total=2, gid 0..4 issued, done one cycle after CYC_END.
- Table tagging: g_logic sequence 6,8,9,1,6 with ready always high -> g_free 1,0,1,0,1 and g_tidx for non-free gates 0 and 1.
- Backpressure: g_ready low for 3 cycles on gid=2 -> gid, g_tidx and g_valid held for 3 cycles, no skip or duplicate accept.
- Multi-cycle: run_cycles=3, gate_size=4 -> 12 accepts; g_cyc 0,1,2; g_first on gid 0 each cycle; g_tidx restarts each cycle.
- Edge sizes:
  - gate_size=0 -> done with zero g_valid cycles.
  - run_cycles=0 -> behaves exactly like run_cycles=1.
  - Second start after done -> no nl_start, issue begins the next cycle.
- Reset mid-ISSUE at gid=3 -> all outputs 0 asynchronously, header_valid cleared; next start pulses nl_start again.

Source files
------------

// File: rtl/gate_scheduler_pkg.sv
// Shared definitions for the gate scheduler and the garbling engine.
//   state_t  : scheduler FSM states
//   XOR_TT / XNOR_TT : truth tables of gates that need no garbled table
//   is_free  : true when a gate's truth table marks it as free (XOR/XNOR)
package gate_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ISSUE,
    ST_CYC_END,
    ST_DONE
  } state_t;

  localparam logic [3:0] XOR_TT  = 4'h6;
  localparam logic [3:0] XNOR_TT = 4'h9;

  function automatic logic is_free(input logic [3:0] g_logic);
    return (g_logic == XOR_TT) || (g_logic == XNOR_TT);
  endfunction

endpackage

// File: rtl/gate_scheduler_counter.sv
// gate_issue_counter: gate id, garbled-table index and sequential cycle
// counters for the gate scheduler.
//   clk, rst     : clock, asynchronous active-high reset
//   i_clr        : clear all counters
//   i_next_cyc   : start the next sequential cycle (gid/tidx to 0, cyc+1)
//   i_accept     : a gate handshake completes this cycle
//   i_free       : accepted gate is free (no table consumed)
//   i_last       : accepted gate is the last of the cycle (gid holds)
//   o_gid        : current gate id
//   o_tidx       : running count of non-free gates in this cycle
//   o_cyc        : current sequential cycle number
module gate_issue_counter #(
  parameter int S = 20,
  parameter int C = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_next_cyc,
  input  logic         i_accept,
  input  logic         i_free,
  input  logic         i_last,
  output logic [S-1:0] o_gid,
  output logic [S-1:0] o_tidx,
  output logic [C-1:0] o_cyc
);

  logic [S-1:0] r_gid;
  logic [S-1:0] r_tidx;
  logic [C-1:0] r_cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gid  <= '0;
      r_tidx <= '0;
      r_cyc  <= '0;
    end else if (i_clr) begin
      r_gid  <= '0;
      r_tidx <= '0;
      r_cyc  <= '0;
    end else if (i_next_cyc) begin
      r_gid  <= '0;
      r_tidx <= '0;
      r_cyc  <= r_cyc + C'(1);
    end else if (i_accept) begin
      if (!i_free) r_tidx <= r_tidx + S'(1);
      if (!i_last) r_gid  <= r_gid + S'(1);
    end
  end

  assign o_gid  = r_gid;
  assign o_tidx = r_tidx;
  assign o_cyc  = r_cyc;

endmodule

// File: rtl/gate_scheduler.sv
// gate_scheduler: sequences the netlist ROM reader (header read, then gate
// addressing) and feeds gate descriptors to the garbling engine over a
// valid/ready handshake, repeated for run_cycles sequential cycles.
//   clk, rst                 : clock, asynchronous active-high reset
//   start, run_cycles        : begin a run of max(run_cycles,1) cycles
//   nl_start / nl_done       : header read request / header-done pulse
//   nl_gate_size, nl_num_xor : header fields, valid with nl_done
//   nl_g_logic               : truth table of the gate addressed by gid
//   gid, g_valid, g_ready    : gate issue handshake
//   g_free, g_tidx, g_first, g_cyc : gate descriptor tags
//   busy, done, tables_total : status and statistics
module gate_scheduler
  import gate_scheduler_pkg::*;
#(
  parameter int S = 20,
  parameter int C = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [C-1:0] run_cycles,
  output logic         nl_start,
  input  logic         nl_done,
  input  logic [S-1:0] nl_gate_size,
  input  logic [S-1:0] nl_num_xor,
  input  logic [3:0]   nl_g_logic,
  output logic [S-1:0] gid,
  output logic         g_valid,
  input  logic         g_ready,
  output logic         g_free,
  output logic [S-1:0] g_tidx,
  output logic         g_first,
  output logic [C-1:0] g_cyc,
  output logic         busy,
  output logic         done,
  output logic [S-1:0] tables_total
);

  state_t       r_state;
  logic         r_header_valid;
  logic [S-1:0] r_gate_size;
  logic [S-1:0] r_num_xor;
  logic [C-1:0] r_run_cycles;
  logic         r_nl_start;
  logic         r_g_valid;
  logic         r_busy;
  logic         r_done;

  logic         w_accept;
  logic         w_free_raw;
  logic         w_last;
  logic         w_more_cyc;
  logic         w_clr;
  logic         w_next_cyc;

  assign w_accept   = r_g_valid & g_ready;
  assign w_free_raw = is_free(nl_g_logic);
  assign w_last     = (gid == (r_gate_size - S'(1)));
  // One bit wider so g_cyc+1 cannot wrap in the comparison.
  assign w_more_cyc = ((C+1)'(g_cyc) + (C+1)'(1)) < (C+1)'(r_run_cycles);
  assign w_clr      = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_next_cyc = (r_state == ST_CYC_END) && w_more_cyc;

  gate_issue_counter #(
    .S(S),
    .C(C)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_next_cyc(w_next_cyc),
    .i_accept  (w_accept),
    .i_free    (w_free_raw),
    .i_last    (w_last),
    .o_gid     (gid),
    .o_tidx    (g_tidx),
    .o_cyc     (g_cyc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_header_valid <= 1'b0;
      r_gate_size    <= '0;
      r_num_xor      <= '0;
      r_run_cycles   <= '0;
      r_nl_start     <= 1'b0;
      r_g_valid      <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_nl_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy       <= 1'b1;
            r_run_cycles <= (run_cycles == '0) ? C'(1) : run_cycles;
            if (!r_header_valid) begin
              r_nl_start <= 1'b1;
              r_state    <= ST_HDR;
            end else if (r_gate_size == '0) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_g_valid <= 1'b1;
              r_state   <= ST_ISSUE;
            end
          end
        end
        ST_HDR: begin
          if (nl_done) begin
            r_gate_size    <= nl_gate_size;
            r_num_xor      <= nl_num_xor;
            r_header_valid <= 1'b1;
            if (nl_gate_size == '0) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_g_valid <= 1'b1;
              r_state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (w_accept && w_last) begin
            r_g_valid <= 1'b0;
            r_state   <= ST_CYC_END;
          end
        end
        ST_CYC_END: begin
          if (w_more_cyc) begin
            r_g_valid <= 1'b1;
            r_state   <= ST_ISSUE;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign nl_start     = r_nl_start;
  assign g_valid      = r_g_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  // Gated so the descriptor tags read 0 whenever nothing is offered.
  assign g_free       = r_g_valid & w_free_raw;
  assign g_first      = r_g_valid & (gid == '0);
  assign tables_total = r_gate_size - r_num_xor;

endmodule

// File: tb/tb_gate_scheduler.sv
module tb_gate_scheduler;

  localparam int S = 20;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [C-1:0] run_cycles = '0;
  logic         nl_start;
  logic         nl_done = 1'b0;
  logic [S-1:0] nl_gate_size = '0;
  logic [S-1:0] nl_num_xor = '0;
  logic [3:0]   nl_g_logic;
  logic [S-1:0] gid;
  logic         g_valid;
  logic         g_ready = 1'b1;
  logic         g_free;
  logic [S-1:0] g_tidx;
  logic         g_first;
  logic [C-1:0] g_cyc;
  logic         busy;
  logic         done;
  logic [S-1:0] tables_total;

  logic [3:0] glog [0:31];

  gate_scheduler #(.S(S), .C(C)) dut (
    .clk(clk), .rst(rst), .start(start), .run_cycles(run_cycles),
    .nl_start(nl_start), .nl_done(nl_done), .nl_gate_size(nl_gate_size),
    .nl_num_xor(nl_num_xor), .nl_g_logic(nl_g_logic), .gid(gid),
    .g_valid(g_valid), .g_ready(g_ready), .g_free(g_free), .g_tidx(g_tidx),
    .g_first(g_first), .g_cyc(g_cyc), .busy(busy), .done(done),
    .tables_total(tables_total)
  );

  // Netlist ROM data path: truth table of the addressed gate.
  assign nl_g_logic = glog[gid[4:0]];

  always #5 clk = ~clk;

  typedef struct {
    int gid;
    bit free;
    int tidx;
    bit first;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_flags"}, {26'd0, nl_start, g_valid, g_free, g_first, busy, done}, 32'd0);
    chk({tag, "_gid"}, 32'(gid), 32'd0);
    chk({tag, "_tidx"}, 32'(g_tidx), 32'd0);
    chk({tag, "_cyc"}, 32'(g_cyc), 32'd0);
    chk({tag, "_ttot"}, 32'(tables_total), 32'd0);
  endtask

  // Runs one start..done sequence while the bench plays the netlist reader
  // (nl_done two cycles after nl_start) and checks every accepted gate
  // against the scoreboard. abort_gid>=0 asserts reset when that gid is offered.
  task automatic run_case(input string name, input int gs, input int nx, input int rc,
                          input bit exp_hdr, input int stall_gid, input int stall_len,
                          input int abort_gid);
    int rcn, tidx, nstart, nvalid, last_acc, stall_left, hdr_wait, total;
    bit in_stall, fin;
    exp_t e;
    rcn = (rc == 0) ? 1 : rc;
    total = 0;
    for (int c = 0; c < rcn; c++) begin
      tidx = 0;
      for (int g = 0; g < gs; g++) begin
        e.gid = g;
        e.free = (glog[g] == 4'h6) || (glog[g] == 4'h9);
        e.tidx = tidx;
        e.first = (g == 0);
        e.cyc = c;
        sbq.push_back(e);
        total++;
        if (!e.free) tidx++;
      end
    end
    nstart = 0; nvalid = 0; last_acc = -100; stall_left = stall_len;
    hdr_wait = 0; in_stall = 0; fin = 0;
    g_ready = 1'b1;
    run_cycles = C'(rc);
    start = 1'b1;
    step();
    start = 1'b0;
    run_cycles = C'(9);  // must be ignored for this run
    chk({name, "_busy_rise"}, 32'(busy), 32'(gs != 0 || exp_hdr));
    if (!exp_hdr && gs != 0) chk({name, "_issue_next"}, 32'(g_valid), 32'd1);
    for (int k = 0; k < 2000; k++) begin
      nl_done = 1'b0;
      if (hdr_wait > 0) begin
        hdr_wait--;
        if (hdr_wait == 0) begin
          nl_done = 1'b1;
          nl_gate_size = S'(gs);
          nl_num_xor = S'(nx);
        end
      end
      if (nl_start) begin
        nstart++;
        hdr_wait = 2;
      end
      if (abort_gid >= 0 && g_valid && gid == S'(abort_gid)) begin
        rst = 1'b1;
        #1;
        check_all_zero({name, "_async_rst"});
        rst = 1'b0;
        sbq.delete();
        nl_done = 1'b0;
        fin = 1;
        break;
      end
      if (done) begin
        if (gs != 0) chk({name, "_done_lat"}, 32'(k - last_acc), 32'd2);
        chk({name, "_busy_fall"}, 32'(busy), 32'd0);
        chk({name, "_nl_start_cnt"}, 32'(nstart), 32'(exp_hdr));
        chk({name, "_sb_left"}, 32'(sbq.size()), 32'd0);
        chk({name, "_ttot"}, 32'(tables_total), 32'(gs - nx));
        chk({name, "_valid_cycles"}, 32'(nvalid), 32'(total + stall_len));
        step();
        chk({name, "_done_1cyc"}, 32'(done), 32'd0);
        chk({name, "_gid_idle"}, 32'(gid), 32'd0);
        fin = 1;
        break;
      end
      if (!in_stall && stall_left > 0 && g_valid && gid == S'(stall_gid)) in_stall = 1;
      if (in_stall) begin
        g_ready = 1'b0;
        chk({name, "_stall_valid"}, 32'(g_valid), 32'd1);
        chk({name, "_stall_gid"}, 32'(gid), 32'(sbq[0].gid));
        chk({name, "_stall_cyc"}, 32'(g_cyc), 32'(sbq[0].cyc));
        if (!sbq[0].free) chk({name, "_stall_tidx"}, 32'(g_tidx), 32'(sbq[0].tidx));
        stall_left--;
        if (stall_left == 0) in_stall = 0;
      end else begin
        g_ready = 1'b1;
      end
      if (g_valid) nvalid++;
      if (g_valid && g_ready) begin
        if (sbq.size() == 0) begin
          chk({name, "_extra_accept"}, 32'(gid), 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk({name, "_gid"}, 32'(gid), 32'(e.gid));
          chk({name, "_free"}, 32'(g_free), 32'(e.free));
          if (!e.free) chk({name, "_tidx"}, 32'(g_tidx), 32'(e.tidx));
          chk({name, "_first"}, 32'(g_first), 32'(e.first));
          chk({name, "_cyc"}, 32'(g_cyc), 32'(e.cyc));
        end
        last_acc = k;
      end
      step();
    end
    if (!fin) chk({name, "_timeout"}, 32'd1, 32'd0);
    g_ready = 1'b1;
    nl_done = 1'b0;
    sbq.delete();
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) glog[i] = 4'h8;
    #2;
    check_all_zero("reset");
    step();
    rst = 1'b0;
    step();

    // Header capture and table tagging: 6,8,9,1,6.
    glog[0] = 4'h6; glog[1] = 4'h8; glog[2] = 4'h9; glog[3] = 4'h1; glog[4] = 4'h6;
    run_case("hdr", 5, 3, 1, 1'b1, -1, 0, -1);
    // Reused header with backpressure on gid 2.
    run_case("bp", 5, 3, 1, 1'b0, 2, 3, -1);

    // Multi-cycle run on a new netlist.
    pulse_reset();
    glog[0] = 4'h8; glog[1] = 4'h6; glog[2] = 4'h1; glog[3] = 4'h9;
    run_case("multi", 4, 2, 3, 1'b1, -1, 0, -1);
    run_case("rc0", 4, 2, 0, 1'b0, -1, 0, -1);
    // Reset in the middle of issue, then header must be read again.
    run_case("abort", 4, 2, 1, 1'b0, -1, 0, 3);
    run_case("reread", 4, 2, 1, 1'b1, 1, 2, -1);

    // Empty netlist.
    pulse_reset();
    run_case("gs0", 0, 0, 2, 1'b1, -1, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
